// File: rtl/event_pulse_generator.sv
// event_pulse_generator: triggered burst of high/low level pulses on a signed DAC-side output.
// Define TOTAL_COUNT_EN to add the saturating pulses_total output.
module event_pulse_generator #(
  parameter int DW = 16,
  parameter int TW = 32,
  parameter int BW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 trig,
  input  logic [TW-1:0]        period,
  input  logic [TW-1:0]        pulse_width,
  input  logic [BW-1:0]        burst_count,
  input  logic signed [DW-1:0] level_high,
  input  logic signed [DW-1:0] level_low,
  output logic signed [DW-1:0] dout,
  output logic                 pulse,
  output logic                 busy,
  output logic [BW-1:0]        pulses_sent,
  output logic                 done
`ifdef TOTAL_COUNT_EN
  ,
  output logic [31:0]          pulses_total
`endif
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t state_q, state_d;
  logic trig_q, done_q, done_d, edge_w, last, fin, complete;
  logic [TW-1:0] timer_q, timer_d, per_q, pw_q, pw_src, pw_m1, pw_eff_s, lo_m1;
  logic [TW:0] lo_diff;
  logic [BW-1:0] bc_q, sent_q, sent_d, sent_inc;
  logic signed [DW-1:0] hi_q, lo_q, dout_q, dout_d;
`ifdef TOTAL_COUNT_EN
  logic [31:0] total_q, total_d;
`endif
  always_comb begin
    edge_w = trig & ~trig_q;
    pw_src = state_q == IDLE ? pulse_width : pw_q;
    pw_m1 = pw_src == '0 ? '0 : pw_src - TW'(1);
    pw_eff_s = pw_q == '0 ? TW'(1) : pw_q;
    // one extra bit so period < pulse width reads as negative instead of wrapping
    lo_diff = {1'b0, per_q} - {1'b0, pw_eff_s};
    lo_m1 = (lo_diff[TW] || lo_diff[TW-1:1] == '0) ? '0 : lo_diff[TW-1:0] - TW'(1);
    last = timer_q == '0;
    sent_inc = sent_q + BW'(1);
    fin = state_q == LOW && last && enable;
    complete = fin && bc_q != '0 && sent_inc == bc_q;
    state_d = state_q;
    timer_d = state_q == IDLE ? timer_q : timer_q - TW'(1);
    sent_d = sent_q;
    done_d = 1'b0;
    if (state_q == IDLE) begin
      if (edge_w && enable) begin
        state_d = HIGH;
        timer_d = pw_m1;
        sent_d = '0;
      end
    end else if (!enable) begin
      state_d = IDLE;
    end else if (state_q == HIGH && last) begin
      state_d = LOW;
      timer_d = lo_m1;
    end else if (fin) begin
      sent_d = sent_inc;
      state_d = complete ? IDLE : HIGH;
      timer_d = pw_m1;
      done_d = complete;
    end
    dout_d = state_d == HIGH ? (state_q == IDLE ? level_high : hi_q) :
             state_d == LOW ? lo_q : level_low;
`ifdef TOTAL_COUNT_EN
    total_d = (fin && total_q != '1) ? total_q + 32'd1 : total_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      trig_q <= 1'b0;
      timer_q <= '0;
      dout_q <= level_low;
      sent_q <= '0;
      done_q <= 1'b0;
      per_q <= '0;
      pw_q <= '0;
      bc_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
`ifdef TOTAL_COUNT_EN
      total_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      trig_q <= trig;
      timer_q <= timer_d;
      dout_q <= dout_d;
      sent_q <= sent_d;
      done_q <= done_d;
      if (state_q == IDLE && state_d == HIGH) begin
        per_q <= period;
        pw_q <= pulse_width;
        bc_q <= burst_count;
        hi_q <= level_high;
        lo_q <= level_low;
      end
`ifdef TOTAL_COUNT_EN
      total_q <= total_d;
`endif
    end
  end
  assign dout = dout_q;
  assign pulse = state_q == HIGH;
  assign busy = state_q != IDLE;
  assign pulses_sent = sent_q;
  assign done = done_q;
`ifdef TOTAL_COUNT_EN
  assign pulses_total = total_q;
`endif
endmodule

// File: doc/event_pulse_generator.md
Name: event_pulse_generator

Overview:
- Source-side counterpart to the event counter: emits bursts of level-defined pulses on a 16-bit signed DAC-side output, for loopback counting and threshold-detector stimulus.
- Sits inside CustomInstrument.
- Driven by control registers and exttrig; reports progress to status registers.

Parameters:
- DW, 16, sample width of the high/low levels and dout.
- TW, 32, width of the period and pulse-width timers.
- BW, 16, width of the burst-count register and the pulse counter.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- enable  input  1  arms generator; deassertion aborts
- trig  input  1  trigger, rising-edge sensitive (exttrig or a control bit)
- period  input  TW  pulse repetition period in clk cycles
- pulse_width  input  TW  high-phase length in clk cycles
- burst_count  input  BW  pulses per burst; 0 = continuous
- level_high  input  DW signed  dout value during the high phase
- level_low  input  DW signed  dout value otherwise
- dout  output  DW signed  generated waveform
- pulse  output  1  high during the high phase
- busy  output  1  burst in progress
- pulses_sent  output  BW  pulses completed in the current/last burst
- done  output  1  one-cycle strobe at burst completion

Behaviour:
- The clock is clk. Reset is synchronous and active-high, on port reset.
- Reset values:
  - State IDLE.
  - dout = level_low, registered.
  - pulse = 0, busy = 0, done = 0, pulses_sent = 0.
  - trig edge register = 0.
- Edge detect: trig_d registers trig. The edge is trig & ~trig_d, evaluated every cycle.
- States:
  - IDLE: dout = level_low, pulse = 0, busy = 0. On edge & enable:
    - latch period, pulse_width, burst_count, level_high and level_low into shadow registers;
    - clear pulses_sent;
    - go to HIGH.
    - Edge without enable is ignored.
  - HIGH: dout = shadow level_high, pulse = 1, busy = 1. Stay pw_eff cycles, where pw_eff = max(pulse_width, 1). Then go to LOW.
  - LOW: dout = shadow level_low, pulse = 0, busy = 1. Stay lo_eff cycles, where lo_eff = max(period − pw_eff, 1); compute in TW+1 bits so the subtraction cannot underflow. On the last LOW cycle:
    - increment pulses_sent;
    - if burst_count ≠ 0 and the new pulses_sent == shadow burst_count, go to IDLE and assert done for the first IDLE cycle;
    - else go to HIGH.
- Latency: edge sampled in cycle t → dout = level_high and pulse = 1 from cycle t+1.
- Actual period = pw_eff + lo_eff. This equals period when period > pw_eff.
- Continuous mode (burst_count = 0):
  - pulses_sent wraps modulo 2^BW.
  - Never self-terminates and never asserts done.
- Triggers while busy are ignored; no retrigger and no queuing.
- Register inputs changing mid-burst have no effect until the next trigger, because shadows are latched at trigger time.
- enable deasserted in HIGH or LOW:
  - next cycle goes to IDLE with dout = level_low and pulse = 0;
  - pulses_sent holds its value;
  - done is not asserted.
- Edge and enable rising in the same cycle counts as a valid trigger.
- Reset mid-burst: immediate return to the reset values on the next clock edge.
- The phase timer is a single TW-bit down-counter. It is loaded with (pw_eff−1) or (lo_eff−1) on state entry, and the transition fires at 0.

Optional Feature:
- Macro: TOTAL_COUNT_EN.
- When defined:
  - adds output pulses_total (32 bits);
  - counts every completed pulse since reset across all bursts;
  - saturates at 0xFFFFFFFF;
  - is cleared only by reset.
- When undefined: the port and its counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then burst_count=3, period=10, pulse_width=4, level_high=16'sd8000, level_low=−16'sd8000, trig edge at cycle 0 → dout=8000 on cycles 1–4, 11–14 and 21–24, −8000 elsewhere; done pulses at cycle 31; pulses_sent=3; busy falls at 31.
- pulse_width=0, period=0, burst_count=2 → each pulse is 1 cycle high and 1 cycle low; done at cycle 5; pulses_sent=2.
- pulse_width=6, period=4 → high 6 cycles, low 1 cycle, period 7.
- burst_count=0, period=5, pulse_width=2, run 1000 cycles → 200 pulses, done never asserted. Then drop enable mid-HIGH → dout returns to level_low on the next cycle and busy=0.
- During a burst, toggle trig again and change period to 100 → no retrigger, the period stays at its latched value. A trig edge with enable=0 → no activity.
- Assert reset in the middle of the LOW phase of pulse 2 → all outputs return to their reset values on the next cycle. With TOTAL_COUNT_EN defined, pulses_total resets to 0 and otherwise accumulates 3+2 across two bursts.
